// File: rtl/rvm_lsu_ctrl.sv
// rvm_lsu_ctrl: load/store sequencer between the control FSM and data memory.
// Ports: lsu_* command/response to control FSM, mem_* data memory port, clk/resetn.
module rvm_lsu_ctrl #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16,
    localparam int STRB_W = XLEN / 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              lsu_req,
    input  logic              lsu_we,
    input  logic [1:0]        lsu_size,
    input  logic              lsu_signed,
    input  logic [XLEN-1:0]   lsu_addr,
    input  logic [XLEN-1:0]   lsu_wdata,
    output logic              lsu_busy,
    output logic              lsu_done,
    output logic [XLEN-1:0]   lsu_rdata,
    output logic              lsu_err,
    output logic [1:0]        lsu_err_cause,
    output logic              mem_req,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [STRB_W-1:0] mem_strb,
    input  logic              mem_ack,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_err
);

    localparam int OFFW = $clog2(STRB_W);
    localparam int CW   = $clog2(TIMEOUT + 2);

    typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            we_q;
    logic [1:0]      size_q;
    logic            sgn_q;
    logic [OFFW-1:0] off_q;

    logic [OFFW-1:0] off_in;
    logic            misal;
    logic            tmo;

    function automatic logic [STRB_W-1:0] size_mask(input logic [1:0] sz);
        logic [STRB_W-1:0] m;
        m = '0;
        for (int i = 0; i < STRB_W; i++)
            m[i] = (i < (1 << sz));
        return m;
    endfunction

    // Shift the addressed lanes down, then push the access to the top
    // of the word and back so the shift-in fills the upper bits.
    function automatic logic [XLEN-1:0] load_ext(
        input logic [XLEN-1:0] rd,
        input logic [OFFW-1:0] off,
        input logic [1:0]      sz,
        input logic            sg
    );
        logic [XLEN-1:0] s;
        logic [XLEN-1:0] l;
        logic [6:0]      sh;
        s = rd >> {off, 3'b000};
        unique case (sz)
            2'b00:   sh = 7'(XLEN - 8);
            2'b01:   sh = 7'(XLEN - 16);
            2'b10:   sh = 7'(XLEN - 32);
            default: sh = 7'd0;
        endcase
        l = s << sh;
        if (sg)
            return $signed(l) >>> sh;
        return l >> sh;
    endfunction

    assign off_in = lsu_addr[OFFW-1:0];

    // Dword is only legal on a 64-bit datapath.
    assign misal = (lsu_size == 2'b01 && lsu_addr[0])
                 | (lsu_size == 2'b10 && |lsu_addr[1:0])
                 | (lsu_size == 2'b11 && (XLEN == 32 || |lsu_addr[2:0]));

    assign tmo = (TIMEOUT > 0) && (cnt == CW'(TIMEOUT - 1));

    assign lsu_busy = (state != IDLE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            cnt           <= '0;
            we_q          <= 1'b0;
            size_q        <= 2'b00;
            sgn_q         <= 1'b0;
            off_q         <= '0;
            lsu_done      <= 1'b0;
            lsu_rdata     <= '0;
            lsu_err       <= 1'b0;
            lsu_err_cause <= 2'b00;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_strb      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (lsu_req) begin
                        we_q   <= lsu_we;
                        size_q <= lsu_size;
                        sgn_q  <= lsu_signed;
                        off_q  <= off_in;
                        if (misal) begin
                            state         <= ERR;
                            lsu_done      <= 1'b1;
                            lsu_err       <= 1'b1;
                            lsu_err_cause <= 2'b01;
                        end else begin
                            state     <= REQ;
                            cnt       <= '0;
                            mem_req   <= 1'b1;
                            mem_we    <= lsu_we;
                            mem_addr  <= {lsu_addr[XLEN-1:OFFW], OFFW'(0)};
                            mem_wdata <= lsu_wdata << {off_in, 3'b000};
                            mem_strb  <= lsu_we ? size_mask(lsu_size) << off_in
                                                : '0;
                        end
                    end
                end
                REQ: begin
                    // Ack is checked first so it wins over timeout expiry.
                    if (mem_ack) begin
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        mem_strb <= '0;
                        lsu_done <= 1'b1;
                        if (mem_err) begin
                            state         <= ERR;
                            lsu_err       <= 1'b1;
                            lsu_err_cause <= 2'b10;
                        end else begin
                            state     <= DONE;
                            lsu_rdata <= we_q ? '0
                                       : load_ext(mem_rdata, off_q, size_q, sgn_q);
                        end
                    end else if (tmo) begin
                        state         <= ERR;
                        mem_req       <= 1'b0;
                        mem_we        <= 1'b0;
                        mem_strb      <= '0;
                        lsu_done      <= 1'b1;
                        lsu_err       <= 1'b1;
                        lsu_err_cause <= 2'b11;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE, ERR: begin
                    state         <= IDLE;
                    lsu_done      <= 1'b0;
                    lsu_err       <= 1'b0;
                    lsu_err_cause <= 2'b00;
                    lsu_rdata     <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rvm_lsu_ctrl.sv
// tb_rvm_lsu_ctrl: directed bench for rvm_lsu_ctrl on RV32 (TIMEOUT=4) and RV64.
// Drives and samples on the falling edge; summary line at the end.
module tb_rvm_lsu_ctrl;

    logic clk;
    logic resetn;

    logic        a_req, a_we, a_sgn;
    logic [1:0]  a_size;
    logic [31:0] a_addr, a_wdata;
    logic        a_busy, a_done, a_err;
    logic [31:0] a_rdata;
    logic [1:0]  a_cause;
    logic        a_mreq, a_mwe;
    logic [31:0] a_maddr, a_mwdata;
    logic [3:0]  a_mstrb;
    logic        a_ack, a_merr;
    logic [31:0] a_mrdata;

    logic        b_req, b_we, b_sgn;
    logic [1:0]  b_size;
    logic [63:0] b_addr, b_wdata;
    logic        b_busy, b_done, b_err;
    logic [63:0] b_rdata;
    logic [1:0]  b_cause;
    logic        b_mreq, b_mwe;
    logic [63:0] b_maddr, b_mwdata;
    logic [7:0]  b_mstrb;
    logic        b_ack, b_merr;
    logic [63:0] b_mrdata;

    int n_chk;
    int n_fail;

    rvm_lsu_ctrl #(.XLEN(32), .TIMEOUT(4)) u_a (
        .clk(clk), .resetn(resetn),
        .lsu_req(a_req), .lsu_we(a_we), .lsu_size(a_size),
        .lsu_signed(a_sgn), .lsu_addr(a_addr), .lsu_wdata(a_wdata),
        .lsu_busy(a_busy), .lsu_done(a_done), .lsu_rdata(a_rdata),
        .lsu_err(a_err), .lsu_err_cause(a_cause),
        .mem_req(a_mreq), .mem_we(a_mwe), .mem_addr(a_maddr),
        .mem_wdata(a_mwdata), .mem_strb(a_mstrb),
        .mem_ack(a_ack), .mem_rdata(a_mrdata), .mem_err(a_merr)
    );

    rvm_lsu_ctrl #(.XLEN(64), .TIMEOUT(16)) u_b (
        .clk(clk), .resetn(resetn),
        .lsu_req(b_req), .lsu_we(b_we), .lsu_size(b_size),
        .lsu_signed(b_sgn), .lsu_addr(b_addr), .lsu_wdata(b_wdata),
        .lsu_busy(b_busy), .lsu_done(b_done), .lsu_rdata(b_rdata),
        .lsu_err(b_err), .lsu_err_cause(b_cause),
        .mem_req(b_mreq), .mem_we(b_mwe), .mem_addr(b_maddr),
        .mem_wdata(b_mwdata), .mem_strb(b_mstrb),
        .mem_ack(b_ack), .mem_rdata(b_mrdata), .mem_err(b_merr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a command for one cycle; returns in cycle 1.
    task automatic a_cmd(input logic we, input logic [1:0] sz,
                         input logic sg, input logic [31:0] ad,
                         input logic [31:0] wd);
        @(negedge clk);
        a_we = we; a_size = sz; a_sgn = sg; a_addr = ad; a_wdata = wd;
        a_req = 1'b1;
        @(negedge clk);
        a_req = 1'b0;
    endtask

    // Ack in the current cycle; returns in the following cycle.
    task automatic a_give(input logic [31:0] rd, input logic er);
        a_ack = 1'b1; a_mrdata = rd; a_merr = er;
        @(negedge clk);
        a_ack = 1'b0; a_merr = 1'b0;
    endtask

    task automatic b_cmd(input logic we, input logic [1:0] sz,
                         input logic sg, input logic [63:0] ad,
                         input logic [63:0] wd);
        @(negedge clk);
        b_we = we; b_size = sz; b_sgn = sg; b_addr = ad; b_wdata = wd;
        b_req = 1'b1;
        @(negedge clk);
        b_req = 1'b0;
    endtask

    task automatic b_give(input logic [63:0] rd);
        b_ack = 1'b1; b_mrdata = rd; b_merr = 1'b0;
        @(negedge clk);
        b_ack = 1'b0;
    endtask

    initial begin
        int n;
        logic seen;
        n_chk = 0;
        n_fail = 0;
        resetn = 1'b0;
        a_req = 0; a_we = 0; a_size = 0; a_sgn = 0; a_addr = 0; a_wdata = 0;
        a_ack = 0; a_mrdata = 0; a_merr = 0;
        b_req = 0; b_we = 0; b_size = 0; b_sgn = 0; b_addr = 0; b_wdata = 0;
        b_ack = 0; b_mrdata = 0; b_merr = 0;

        // Reset state
        @(negedge clk);
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_mreq", a_mreq, 0);
        chk("rst_maddr", a_maddr, 0);
        chk("rst_strb", a_mstrb, 0);
        chk("rst_cause", a_cause, 0);
        chk("rst_b_rdata", b_rdata, 0);
        resetn = 1'b1;

        // Load word at 0x100, two wait cycles; busy request is ignored
        a_cmd(0, 2'b10, 0, 32'h100, 0);
        chk("lw_c1_mreq", a_mreq, 1);
        chk("lw_c1_we", a_mwe, 0);
        chk("lw_c1_addr", a_maddr, 32'h100);
        chk("lw_c1_strb", a_mstrb, 0);
        chk("lw_c1_busy", a_busy, 1);
        a_req = 1'b1; a_addr = 32'h101; a_we = 1'b1;
        @(negedge clk);
        chk("lw_c2_mreq", a_mreq, 1);
        @(negedge clk);
        chk("lw_c3_mreq", a_mreq, 1);
        chk("lw_c3_addr", a_maddr, 32'h100);
        chk("lw_c3_we", a_mwe, 0);
        chk("lw_c3_done", a_done, 0);
        a_give(32'hDEADBEEF, 0);
        chk("lw_done", a_done, 1);
        chk("lw_err", a_err, 0);
        chk("lw_rdata", a_rdata, 32'hDEADBEEF);
        chk("lw_mreq_off", a_mreq, 0);
        @(negedge clk);
        a_req = 1'b0;
        chk("lw_c5_done", a_done, 0);
        chk("lw_c5_busy", a_busy, 0);
        @(negedge clk);
        chk("lw_c6_busy", a_busy, 0);
        chk("lw_c6_done", a_done, 0);

        // Signed / unsigned byte at 0x103
        a_cmd(0, 2'b00, 1, 32'h103, 0);
        chk("lbs_addr", a_maddr, 32'h100);
        a_give(32'h80FFFFFF, 0);
        chk("lbs_rdata", a_rdata, 32'hFFFFFF80);
        a_cmd(0, 2'b00, 0, 32'h103, 0);
        a_give(32'h80FFFFFF, 0);
        chk("lbu_rdata", a_rdata, 32'h00000080);

        // Half loads
        a_cmd(0, 2'b01, 1, 32'h102, 0);
        a_give(32'h80017FFF, 0);
        chk("lhs_rdata", a_rdata, 32'hFFFF8001);
        a_cmd(0, 2'b01, 1, 32'h000, 0);
        a_give(32'h80017FFF, 0);
        chk("lh_pos_rdata", a_rdata, 32'h00007FFF);

        // Store half 0x1234 at 0x102
        a_cmd(1, 2'b01, 0, 32'h102, 32'h00001234);
        chk("sh_mreq", a_mreq, 1);
        chk("sh_we", a_mwe, 1);
        chk("sh_addr", a_maddr, 32'h100);
        chk("sh_strb", a_mstrb, 4'b1100);
        chk("sh_wdata", a_mwdata, 32'h12340000);
        a_give(32'hFFFFFFFF, 0);
        chk("sh_done", a_done, 1);
        chk("sh_err", a_err, 0);
        chk("sh_rdata", a_rdata, 0);

        // Store byte at 0x101
        a_cmd(1, 2'b00, 0, 32'h101, 32'h000000AB);
        chk("sb_strb", a_mstrb, 4'b0010);
        chk("sb_wdata", a_mwdata, 32'h0000AB00);
        a_give(0, 0);
        chk("sb_done", a_done, 1);

        // Misaligned word, illegal dword on RV32
        a_cmd(0, 2'b10, 0, 32'h101, 0);
        chk("mis_mreq", a_mreq, 0);
        chk("mis_done", a_done, 1);
        chk("mis_err", a_err, 1);
        chk("mis_cause", a_cause, 2'b01);
        chk("mis_rdata", a_rdata, 0);
        @(negedge clk);
        chk("mis_c2_done", a_done, 0);
        chk("mis_c2_cause", a_cause, 0);
        a_cmd(0, 2'b11, 0, 32'h100, 0);
        chk("d32_mreq", a_mreq, 0);
        chk("d32_err", a_err, 1);
        chk("d32_cause", a_cause, 2'b01);

        // Timeout after exactly 4 request cycles
        a_cmd(0, 2'b10, 0, 32'h200, 0);
        n = 0;
        while (a_mreq && n < 10) begin
            n++;
            @(negedge clk);
        end
        chk("tmo_cycles", n, 4);
        chk("tmo_done", a_done, 1);
        chk("tmo_err", a_err, 1);
        chk("tmo_cause", a_cause, 2'b11);

        // Ack on the last timeout cycle wins
        a_cmd(0, 2'b10, 0, 32'h204, 0);
        repeat (3) @(negedge clk);
        chk("race_mreq", a_mreq, 1);
        a_give(32'h11223344, 0);
        chk("race_done", a_done, 1);
        chk("race_err", a_err, 0);
        chk("race_rdata", a_rdata, 32'h11223344);

        // Bus error
        a_cmd(0, 2'b10, 0, 32'h300, 0);
        a_give(32'h55555555, 1);
        chk("berr_done", a_done, 1);
        chk("berr_err", a_err, 1);
        chk("berr_cause", a_cause, 2'b10);
        chk("berr_rdata", a_rdata, 0);

        // Ack while idle is ignored
        @(negedge clk);
        @(negedge clk);
        a_ack = 1'b1;
        @(negedge clk);
        @(negedge clk);
        a_ack = 1'b0;
        chk("idle_ack_busy", a_busy, 0);
        chk("idle_ack_done", a_done, 0);

        // RV64 dword load at 0x8
        b_cmd(0, 2'b11, 0, 64'h8, 0);
        chk("ld_mreq", b_mreq, 1);
        chk("ld_addr", b_maddr, 64'h8);
        chk("ld_strb", b_mstrb, 0);
        b_give(64'h0123456789ABCDEF);
        chk("ld_done", b_done, 1);
        chk("ld_rdata", b_rdata, 64'h0123456789ABCDEF);

        // RV64 store word at 0x4
        b_cmd(1, 2'b10, 0, 64'h4, 64'h00000000DDCCBBAA);
        chk("sw64_addr", b_maddr, 64'h0);
        chk("sw64_strb", b_mstrb, 8'hF0);
        chk("sw64_wdata", b_mwdata, 64'hDDCCBBAA00000000);
        b_give(0);
        chk("sw64_rdata", b_rdata, 0);

        // RV64 signed word at 0xC
        b_cmd(0, 2'b10, 1, 64'hC, 0);
        b_give(64'h8000000000000000);
        chk("lw64_rdata", b_rdata, 64'hFFFFFFFF80000000);

        // RV64 misaligned dword
        b_cmd(0, 2'b11, 0, 64'h4, 0);
        chk("mis64_mreq", b_mreq, 0);
        chk("mis64_cause", b_cause, 2'b01);

        // Reset in the middle of a request
        @(negedge clk);
        b_cmd(0, 2'b11, 0, 64'h10, 0);
        chk("rr_mreq", b_mreq, 1);
        #2 resetn = 1'b0;
        #1;
        chk("rr_mreq_drop", b_mreq, 0);
        chk("rr_busy", b_busy, 0);
        @(negedge clk);
        resetn = 1'b1;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen = seen | b_done;
        end
        chk("rr_no_done", seen, 0);
        b_cmd(0, 2'b11, 0, 64'h10, 0);
        chk("rr_next_mreq", b_mreq, 1);
        b_give(64'hCAFEF00D12345678);
        chk("rr_next_done", b_done, 1);
        chk("rr_next_rdata", b_rdata, 64'hCAFEF00D12345678);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
